// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity type codes,
// legal oversampling ratios and the 3-sample majority vote.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int PRSC_8  = 8;
    localparam int PRSC_16 = 16;
    localparam int PRSC_32 = 32;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling timer: counts CLK cycles within a bit, captures RX_IN
// at the three mid-bit positions and flags the end of each bit period.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRSC_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  rx_in,
    input  logic [PRSC_WIDTH-1:0] prescale,
    output logic                  bit_wrap,
    output logic                  sample_last,
    output logic                  bit_now,
    output logic                  bit_val
);

    localparam logic [PRSC_WIDTH-1:0] ONE = PRSC_WIDTH'(1);

    logic [PRSC_WIDTH-1:0] edge_cnt;
    logic [PRSC_WIDTH-1:0] half;
    logic [2:0]            samples;

    assign half        = prescale >> 1;
    assign bit_wrap    = run && (edge_cnt == prescale - ONE);
    assign sample_last = run && (edge_cnt == half + ONE);

    // bit_now folds in the live line so the start-bit glitch check can act on the third sample edge
    assign bit_val = maj3(samples[0], samples[1], samples[2]);
    assign bit_now = maj3(samples[0], samples[1], rx_in);

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            edge_cnt <= '0;
        end else if (bit_wrap) begin
            edge_cnt <= '0;
        end else begin
            edge_cnt <= edge_cnt + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            samples <= '0;
        end else if (run) begin
            if (edge_cnt == half - ONE) samples[0] <= rx_in;
            if (edge_cnt == half)       samples[1] <= rx_in;
            if (edge_cnt == half + ONE) samples[2] <= rx_in;
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// UART frame receiver: start/data/parity/stop sequencing on top of the
// oversampling sampler, with registered byte, valid and error pulses.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRSC_WIDTH = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRSC_WIDTH-1:0] Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int              BIT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    rx_state_e state;
    rx_state_e next_state;

    logic                  par_en_q;
    logic                  par_typ_q;
    logic [PRSC_WIDTH-1:0] prsc_q;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  par_bad;
    logic                  par_exp;

    logic run;
    logic bit_wrap;
    logic sample_last;
    logic bit_now;
    logic bit_val;

    assign run     = (state != IDLE);
    assign par_exp = (par_typ_q == PAR_ODD) ? ~^shift_reg : ^shift_reg;

    uart_rx_sampler #(
        .PRSC_WIDTH(PRSC_WIDTH)
    ) u_sampler (
        .clk        (CLK),
        .rst        (RST),
        .run        (run),
        .rx_in      (RX_IN),
        .prescale   (prsc_q),
        .bit_wrap   (bit_wrap),
        .sample_last(sample_last),
        .bit_now    (bit_now),
        .bit_val    (bit_val)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (!RX_IN) next_state = START;
            START: begin
                if (sample_last && bit_now) begin
                    next_state = IDLE;
                end else if (bit_wrap) begin
                    next_state = DATA;
                end
            end
            DATA: begin
                if (bit_wrap && (bit_cnt == LAST_BIT)) begin
                    next_state = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: if (bit_wrap) next_state = STOP;
            STOP:   if (bit_wrap) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Frame config is captured on the start edge so mid-frame input changes are ignored
    always_ff @(posedge CLK) begin
        if (RST) begin
            par_en_q   <= 1'b0;
            par_typ_q  <= PAR_EVEN;
            prsc_q     <= PRSC_WIDTH'(PRSC_8);
            bit_cnt    <= '0;
            shift_reg  <= '0;
            par_bad    <= 1'b0;
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (!RX_IN) begin
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
                        prsc_q    <= Prescale;
                        bit_cnt   <= '0;
                        par_bad   <= 1'b0;
                    end
                end
                DATA: begin
                    if (bit_wrap) begin
                        shift_reg <= {bit_val, shift_reg[DATA_WIDTH-1:1]};
                        bit_cnt   <= bit_cnt + BIT_W'(1);
                    end
                end
                PARITY: begin
                    if (bit_wrap && (bit_val != par_exp)) begin
                        par_bad <= 1'b1;
                        par_err <= 1'b1;
                    end
                end
                STOP: begin
                    if (bit_wrap) begin
                        if (!bit_val) begin
                            stp_err <= 1'b1;
                        end else if (!par_bad) begin
                            P_DATA     <= shift_reg;
                            data_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed serial driver with a per-frame scoreboard of expected output pulses
// (kind, byte on P_DATA, cycle relative to the start edge).
module tb_uart_rx_frame;
    import uart_pkg::*;

    localparam int DW = 8;
    localparam int PW = 6;

    localparam logic [2:0] EV_DV = 3'b100;
    localparam logic [2:0] EV_PE = 3'b010;
    localparam logic [2:0] EV_SE = 3'b001;

    typedef struct packed {
        logic [2:0]    kind;
        logic [DW-1:0] pdata;
        int            cyc;
    } event_t;

    logic          CLK_tb = 1'b0;
    logic          RST = 1'b1;
    logic          RX_IN = 1'b1;
    logic          PAR_EN = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic [PW-1:0] Prescale = PW'(PRSC_8);
    logic [DW-1:0] P_DATA;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;

    event_t        exp_q[$];
    event_t        obs_q[$];
    int            cyc = 0;
    int            checks = 0;
    int            passed = 0;
    logic [DW-1:0] last_good = '0;

    uart_rx_frame #(
        .DATA_WIDTH(DW),
        .PRSC_WIDTH(PW)
    ) dut (
        .CLK       (CLK_tb),
        .RST       (RST),
        .RX_IN     (RX_IN),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .Prescale  (Prescale),
        .P_DATA    (P_DATA),
        .data_valid(data_valid),
        .par_err   (par_err),
        .stp_err   (stp_err)
    );

    always #5 CLK_tb = ~CLK_tb;

    always @(posedge CLK_tb) cyc <= cyc + 1;

    always @(negedge CLK_tb) begin
        if (data_valid === 1'b1 || par_err === 1'b1 || stp_err === 1'b1)
            obs_q.push_back('{kind: {data_valid, par_err, stp_err}, pdata: P_DATA, cyc: cyc});
    end

    // Drives one frame (optionally corrupted) and records the pulse it must cause
    task automatic send_frame(input logic [DW-1:0] data, input int p, input logic pen,
                              input logic ptyp, input logic bad_par, input logic bad_stop);
        logic line_q[$];
        logic pbit;
        int   start;
        int   nbits;
        pbit = 1'(($countones(data) + (ptyp ? 1 : 0)) % 2);
        if (bad_par) pbit = ~pbit;
        line_q.push_back(1'b0);
        for (int i = 0; i < DW; i++) line_q.push_back(data[i]);
        if (pen) line_q.push_back(pbit);
        line_q.push_back(~bad_stop);
        nbits = pen ? 11 : 10;

        PAR_EN = pen;
        PAR_TYP = ptyp;
        Prescale = PW'(p);
        @(posedge CLK_tb);
        #1;
        start = cyc + 1;
        if (bad_stop) begin
            if (pen && bad_par) exp_q.push_back('{kind: EV_PE, pdata: last_good, cyc: start + 10 * p});
            exp_q.push_back('{kind: EV_SE, pdata: last_good, cyc: start + nbits * p});
        end else if (pen && bad_par) begin
            exp_q.push_back('{kind: EV_PE, pdata: last_good, cyc: start + 10 * p});
        end else begin
            exp_q.push_back('{kind: EV_DV, pdata: data, cyc: start + nbits * p});
            last_good = data;
        end
        foreach (line_q[i]) begin
            RX_IN = line_q[i];
            repeat (p) @(posedge CLK_tb);
            #1;
            if (i == 0) begin
                PAR_EN = ~pen;
                PAR_TYP = ~ptyp;
                Prescale = PW'((p == PRSC_8) ? PRSC_32 : PRSC_8);
            end
        end
        RX_IN = 1'b1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        RX_IN = 1'b1;
        repeat (3) @(posedge CLK_tb);
        #1;
        checks++;
        if (P_DATA !== '0) $display("[TB] FAIL reset_pdata: got %h, required 00", P_DATA);
        else passed++;
        checks++;
        if (data_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b, required 0", data_valid);
        else passed++;
        checks++;
        if (par_err !== 1'b0) $display("[TB] FAIL reset_par_err: got %b, required 0", par_err);
        else passed++;
        checks++;
        if (stp_err !== 1'b0) $display("[TB] FAIL reset_stp_err: got %b, required 0", stp_err);
        else passed++;
        RST = 1'b0;
        last_good = '0;
        repeat (3) @(posedge CLK_tb);
        #1;
        obs_q.delete();
    endtask

    task automatic test_even_parity_p8();
        event_t e;
        event_t o;
        send_frame(8'hF0, PRSC_8, 1'b1, PAR_EVEN, 1'b0, 1'b0);
        repeat (20) @(posedge CLK_tb);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                $display("[TB] FAIL even_p8_event: no pulse, required kind=%b data=%h cycle=%0d", e.kind, e.pdata, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e)
                    $display("[TB] FAIL even_p8_event: got kind=%b data=%h cycle=%0d, required kind=%b data=%h cycle=%0d",
                             o.kind, o.pdata, o.cyc, e.kind, e.pdata, e.cyc);
                else passed++;
            end
        end
        checks++;
        if (obs_q.size() !== 0) $display("[TB] FAIL even_p8_extra: got %0d extra pulses, required 0", obs_q.size());
        else passed++;
        obs_q.delete();
    endtask

    task automatic test_parity_error_p16();
        event_t e;
        event_t o;
        send_frame(8'hA5, PRSC_16, 1'b1, PAR_ODD, 1'b1, 1'b0);
        repeat (40) @(posedge CLK_tb);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                $display("[TB] FAIL par_err_p16_event: no pulse, required kind=%b data=%h cycle=%0d", e.kind, e.pdata, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e)
                    $display("[TB] FAIL par_err_p16_event: got kind=%b data=%h cycle=%0d, required kind=%b data=%h cycle=%0d",
                             o.kind, o.pdata, o.cyc, e.kind, e.pdata, e.cyc);
                else passed++;
            end
        end
        checks++;
        if (obs_q.size() !== 0) $display("[TB] FAIL par_err_p16_extra: got %0d extra pulses, required 0", obs_q.size());
        else passed++;
        checks++;
        if (P_DATA !== last_good) $display("[TB] FAIL par_err_p16_hold: got %h, required %h", P_DATA, last_good);
        else passed++;
        obs_q.delete();
    endtask

    task automatic test_stop_error_p32();
        event_t e;
        event_t o;
        send_frame(8'h3C, PRSC_32, 1'b0, PAR_EVEN, 1'b0, 1'b1);
        repeat (40) @(posedge CLK_tb);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                $display("[TB] FAIL stp_err_p32_event: no pulse, required kind=%b data=%h cycle=%0d", e.kind, e.pdata, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e)
                    $display("[TB] FAIL stp_err_p32_event: got kind=%b data=%h cycle=%0d, required kind=%b data=%h cycle=%0d",
                             o.kind, o.pdata, o.cyc, e.kind, e.pdata, e.cyc);
                else passed++;
            end
        end
        checks++;
        if (obs_q.size() !== 0) $display("[TB] FAIL stp_err_p32_extra: got %0d extra pulses, required 0", obs_q.size());
        else passed++;
        obs_q.delete();
    endtask

    task automatic test_start_glitch();
        event_t e;
        event_t o;
        PAR_EN = 1'b0;
        PAR_TYP = PAR_EVEN;
        Prescale = PW'(PRSC_8);
        @(posedge CLK_tb);
        #1;
        RX_IN = 1'b0;
        repeat (3) @(posedge CLK_tb);
        #1;
        RX_IN = 1'b1;
        repeat (20) @(posedge CLK_tb);
        #1;
        checks++;
        if (obs_q.size() !== 0) $display("[TB] FAIL glitch_no_pulse: got %0d pulses, required 0", obs_q.size());
        else passed++;
        obs_q.delete();
        send_frame(8'h55, PRSC_8, 1'b0, PAR_EVEN, 1'b0, 1'b0);
        repeat (20) @(posedge CLK_tb);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                $display("[TB] FAIL glitch_next_event: no pulse, required kind=%b data=%h cycle=%0d", e.kind, e.pdata, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e)
                    $display("[TB] FAIL glitch_next_event: got kind=%b data=%h cycle=%0d, required kind=%b data=%h cycle=%0d",
                             o.kind, o.pdata, o.cyc, e.kind, e.pdata, e.cyc);
                else passed++;
            end
        end
        checks++;
        if (obs_q.size() !== 0) $display("[TB] FAIL glitch_next_extra: got %0d extra pulses, required 0", obs_q.size());
        else passed++;
        obs_q.delete();
    endtask

    task automatic test_back_to_back();
        event_t e;
        event_t o;
        send_frame(8'h01, PRSC_8, 1'b1, PAR_EVEN, 1'b0, 1'b0);
        send_frame(8'hFE, PRSC_8, 1'b1, PAR_EVEN, 1'b0, 1'b0);
        repeat (20) @(posedge CLK_tb);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                $display("[TB] FAIL b2b_event: no pulse, required kind=%b data=%h cycle=%0d", e.kind, e.pdata, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e)
                    $display("[TB] FAIL b2b_event: got kind=%b data=%h cycle=%0d, required kind=%b data=%h cycle=%0d",
                             o.kind, o.pdata, o.cyc, e.kind, e.pdata, e.cyc);
                else passed++;
            end
        end
        checks++;
        if (obs_q.size() !== 0) $display("[TB] FAIL b2b_extra: got %0d extra pulses, required 0", obs_q.size());
        else passed++;
        obs_q.delete();
    endtask

    task automatic test_reset_abort();
        event_t e;
        event_t o;
        PAR_EN = 1'b0;
        PAR_TYP = PAR_EVEN;
        Prescale = PW'(PRSC_8);
        @(posedge CLK_tb);
        #1;
        RX_IN = 1'b0;
        repeat (PRSC_8) @(posedge CLK_tb);
        #1;
        RX_IN = 1'b1;
        repeat (20) @(posedge CLK_tb);
        #1;
        RST = 1'b1;
        repeat (2) @(posedge CLK_tb);
        #1;
        RST = 1'b0;
        last_good = '0;
        repeat (100) @(posedge CLK_tb);
        #1;
        checks++;
        if (obs_q.size() !== 0) $display("[TB] FAIL abort_no_pulse: got %0d pulses, required 0", obs_q.size());
        else passed++;
        checks++;
        if (P_DATA !== '0) $display("[TB] FAIL abort_pdata: got %h, required 00", P_DATA);
        else passed++;
        obs_q.delete();
        send_frame(8'h81, PRSC_8, 1'b0, PAR_EVEN, 1'b0, 1'b0);
        repeat (20) @(posedge CLK_tb);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                $display("[TB] FAIL abort_next_event: no pulse, required kind=%b data=%h cycle=%0d", e.kind, e.pdata, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e)
                    $display("[TB] FAIL abort_next_event: got kind=%b data=%h cycle=%0d, required kind=%b data=%h cycle=%0d",
                             o.kind, o.pdata, o.cyc, e.kind, e.pdata, e.cyc);
                else passed++;
            end
        end
        checks++;
        if (obs_q.size() !== 0) $display("[TB] FAIL abort_next_extra: got %0d extra pulses, required 0", obs_q.size());
        else passed++;
        obs_q.delete();
    endtask

    initial begin
        $display("[TB] uart_rx_frame bench start");
        test_reset();
        test_even_parity_p8();
        test_parity_error_p16();
        test_stop_error_p32();
        test_start_glitch();
        test_back_to_back();
        test_reset_abort();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
